// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: control-bus bit positions,
// access-size decode and the misalign counter width.
package mem_pkg;

    localparam int MEMWRITE = 3;
    localparam int MEMRHALF = 2;
    localparam int MEMRBYTE = 1;
    localparam int MEMEXT   = 0;

    localparam int MISALIGN_CNT_W = 8;
    typedef logic [MISALIGN_CNT_W-1:0] mis_cnt_t;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } access_size_e;

    // Byte wins over half when both request bits are set.
    function automatic access_size_e decode_size(input logic [3:0] ctrl);
        if (ctrl[MEMRBYTE]) return SZ_BYTE;
        if (ctrl[MEMRHALF]) return SZ_HALF;
        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input access_size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select with sign/zero extension, plus byte-write enables, for a
// little-endian 32-bit word addressed by byte offset.
module mem_load_align
    import mem_pkg::*;
(
    input  access_size_e size,
    input  logic [1:0]   addr_lo,
    input  logic         ext,
    input  logic [31:0]  word_in,
    output logic [31:0]  load_data,
    output logic [3:0]   byte_en
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch.
        sel_byte  = word_in[{addr_lo, 3'b000} +: 8];
        sel_half  = word_in[{addr_lo[1], 4'b0000} +: 16];
        load_data = word_in;
        byte_en   = 4'b1111;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{ext & sel_byte[7]}}, sel_byte};
                byte_en   = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                load_data = {{16{ext & sel_half[15]}}, sel_half};
                byte_en   = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Dual-port data memory: port A word fetch, port B byte/half/word load-store with
// misalign tracking. Define MEM_CLEAR_EN to zero-clear the array after reset.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      init,
    input  logic [31:0]               AddressBusA,
    output logic [31:0]               DataBusA,
    input  logic [31:0]               AddressBusB,
    input  logic [31:0]               DataBusIn,
    input  logic [3:0]                ContralBus,
    output logic [31:0]               DataBusB,
    output logic                      Busy,
    output logic                      MisalignErr,
    output logic [MISALIGN_CNT_W-1:0] MisalignCount
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2-1:0] word_idx_t;

    logic [31:0]  mem_q [DEPTH];
    word_idx_t    idx_a;
    word_idx_t    idx_b;
    access_size_e size_b;
    logic         misalign_b;
    logic         active;
    logic [31:0]  word_b;
    logic [31:0]  load_b;
    logic [31:0]  store_data;
    logic [3:0]   be_b;

    logic         wr_en;
    word_idx_t    wr_idx;
    logic [3:0]   wr_be;
    logic [31:0]  wr_data;

    logic [31:0]  data_a_q, data_a_d;
    logic [31:0]  data_b_q, data_b_d;
    logic         err_q, err_d;
    mis_cnt_t     cnt_q, cnt_d;
    logic         unused_addr;

    assign idx_a       = AddressBusA[DEPTH_LOG2+1:2];
    assign idx_b       = AddressBusB[DEPTH_LOG2+1:2];
    assign unused_addr = ^{AddressBusA[31:DEPTH_LOG2+2], AddressBusA[1:0],
                           AddressBusB[31:DEPTH_LOG2+2]};
    assign size_b      = decode_size(ContralBus);
    assign misalign_b  = is_misaligned(size_b, AddressBusB[1:0]);
    assign word_b      = mem_q[idx_b];

    mem_load_align u_align (
        .size      (size_b),
        .addr_lo   (AddressBusB[1:0]),
        .ext       (ContralBus[MEMEXT]),
        .word_in   (word_b),
        .load_data (load_b),
        .byte_en   (be_b)
    );

    always_comb begin
        store_data = DataBusIn;
        case (size_b)
            SZ_BYTE: store_data = {4{DataBusIn[7:0]}};
            SZ_HALF: store_data = {2{DataBusIn[15:0]}};
            default: ;
        endcase
    end

`ifdef MEM_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_READY} clr_state_e;

    clr_state_e state_q, state_d;
    word_idx_t  clr_idx_q, clr_idx_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + word_idx_t'(1);
            if (clr_idx_q == '1) state_d = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!init) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign active = (state_q == ST_READY);
    assign Busy   = ~active;
`else
    assign active = 1'b1;
    assign Busy   = 1'b0;
`endif

    always_comb begin
        data_a_d = '0;
        data_b_d = '0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_idx   = idx_b;
        wr_be    = be_b;
        wr_data  = store_data;
        if (active) begin
            data_a_d = mem_q[idx_a];
            if (misalign_b) begin
                err_d = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + mis_cnt_t'(1);
            end else begin
                data_b_d = load_b;
                wr_en    = ContralBus[MEMWRITE];
            end
        end
`ifdef MEM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_q;
            wr_be   = 4'b1111;
            wr_data = '0;
        end
`endif
    end

    // NOTE: the array has no reset; its contents survive init and need no reset fan-out.
    always_ff @(posedge clk) begin
        if (init && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Reads sample the array in the same edge as the write, so a colliding
    // port A read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (!init) begin
            data_a_q <= '0;
            data_b_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign DataBusA      = data_a_q;
    assign DataBusB      = data_b_q;
    assign MisalignErr   = err_q;
    assign MisalignCount = cnt_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Dual-port synchronous memory that answers the CPU's two bus initiators.
- Port A is read-only and serves instruction fetch on AddressBusA.
- Port B is read/write and serves the MEM stage via AddressBusB, the CPU's DataBusOut and ContralBus, with byte, halfword and word access and load sign/zero extension.
- It tracks misaligned accesses and, optionally, zero-clears itself after reset.

## Interface
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (byte address bits used = DEPTH_LOG2+2; higher address bits ignored, wrap).
- clk  in  1  single clock, all state updates on posedge.
- init  in  1  reset, synchronous, active-low.
- AddressBusA  in  32  instruction byte address.
- DataBusA  out  32  instruction word (drives CPU DataBusInA).
- AddressBusB  in  32  data byte address.
- DataBusIn  in  32  store data (from CPU DataBusOut).
- ContralBus  in  4  {MemWrite, Memrhalf, Memrbyte, MemExt}.
- DataBusB  out  32  load data (drives CPU DataBusInB).
- Busy  out  1  memory clearing, accesses ignored.
- MisalignErr  out  1  sticky misaligned-access flag.
- MisalignCount  out  8  saturating misaligned-access count.

## Operation
- Word index = addr[DEPTH_LOG2+1:2]; little-endian, byte lane = addr[1:0], half lane = addr[1].
- Size decode:
  - Memrbyte=1 → byte, priority over Memrhalf.
  - else Memrhalf=1 → half.
  - else → word.
- Port A: always a word read; addr[1:0] ignored.
- Port B load, when MemWrite=0:
  - Byte: selected byte, extended to 32 bits; MemExt=1 sign-extends, MemExt=0 zero-extends.
  - Half: selected half, extended by the same rule.
  - Word: full word.
- Port B store, when MemWrite=1:
  - Byte writes lane addr[1:0] with DataBusIn[7:0].
  - Half writes lanes {addr[1],1}/{addr[1],0} with DataBusIn[15:0].
  - Word writes all lanes.
  - Untouched lanes are preserved.
  - DataBusB during a store = old word content, aligned/extended as a load.
- Misaligned access on port B: half with addr[0]=1, or word with addr[1:0]≠0.
  - Write suppressed.
  - DataBusB ← 0.
  - MisalignErr ← 1.
  - MisalignCount += 1, saturating at 255.
- Port B is always active, so an idle bus (ContralBus=0) performs a word read of AddressBusB every cycle.
- Port A and B to the same word in the same cycle, with B storing: A returns the old (pre-write) word.
- Port B store followed by a load of the same word next cycle: the load returns the new data.
- MisalignErr and MisalignCount are cleared only by reset.

## Timing
- Reads are registered. The address is sampled at posedge N and DataBusA/DataBusB are valid after posedge N, stable through the following negedge, where the CPU captures.
- Latency is 1 cycle on both ports.
- Stores commit at the posedge that samples MemWrite=1.
- Misalign flag and count update at the same posedge.
- Reset (init=0 at posedge):
  - DataBusA=0, DataBusB=0, MisalignErr=0, MisalignCount=0.
  - Memory contents are untouched unless MEM_CLEAR_EN is defined.
  - Busy=1 when MEM_CLEAR_EN is defined, otherwise 0.

## Configuration
- MEM_CLEAR_EN defined: a 2-state FSM runs after reset.
  - CLEAR: a word counter starts at 0 on the first posedge with init=1 and writes 0 to one word per cycle. Busy=1. Port A/B outputs are held 0, stores are dropped and misalign checks are disabled.
  - After word 2^DEPTH_LOG2−1 is written → READY, Busy=0 from the next cycle, for a total of 2^DEPTH_LOG2 Busy cycles.
  - Reset asserted mid-clear restarts the counter at 0.
- MEM_CLEAR_EN undefined:
  - No FSM and no counter.
  - Busy tied 0.
  - Memory contents after power-up are unspecified and retained across reset.

## Structure
- Shared package mem_pkg holds:
  - ContralBus bit positions (MEMWRITE=3, MEMRHALF=2, MEMRBYTE=1, MEMEXT=0).
  - An access-size enum {SZ_WORD, SZ_HALF, SZ_BYTE}.
  - The misalign-count width constant.
- One sub-module, mem_load_align, selects and extends the load lane and computes byte-write enables from size, addr[1:0] and MemExt. It is reused by the CPU side if WB-stage alignment moves later.
- The storage array, registered outputs, misalign tracking and the clear FSM live in the top module.

## Test plan
- Word store then load: store 0x8765_4321 to 0x10, then a word load from 0x10 → DataBusB=0x8765_4321 one cycle later; port A at 0x10 the same cycle → 0x8765_4321.
- Byte loads: with word 0x8765_4321 at 0x10, load byte 0x13 with MemExt=1 → 0xFFFF_FF87; with MemExt=0 → 0x0000_0087.
- Half load: half 0x12 with MemExt=1 → 0xFFFF_8765.
- Byte/half stores: store byte 0xAA to 0x11, then half 0xBEEF to 0x12; a word load from 0x10 → 0xBEEF_AA21.
- Misalign: word store of 0xDEAD_BEEF to 0x11 → word 0x10 unchanged, DataBusB=0, MisalignErr=1, MisalignCount=1; 300 misaligned accesses → count=255.
- Same-cycle conflict: port A reads 0x20 while B stores 0x1111_1111 to 0x20 → A=old word; A reads 0x20 next cycle → 0x1111_1111.
- MEM_CLEAR_EN, DEPTH_LOG2=4: release reset → Busy high exactly 16 cycles, then all words read 0; a store issued during Busy is dropped; reset at cycle 8 → Busy lasts 16 more cycles.
